// File: rtl/axis_strobed_reader_if.sv
// Stream handshake between the TX sample FIFO (master) and the strobed
// reader (slave). The FIFO presents data/valid; the reader answers with
// a one-cycle pop request on s_tready.
interface axis_strobed_reader_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] s_tdata;
  logic             s_tvalid;
  logic             s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    output s_tready
  );
endinterface

// File: rtl/axis_strobed_reader.sv
// Strobed drain engine for the TX sample FIFO.
// Waits for a prefill occupancy, then pops one sample per sample_strobe and
// presents it as a registered, strobe-aligned sample with a last flag.
// An empty FIFO on a strobe still fills the DAC slot and sets a sticky
// underrun flag without consuming packet length.
// Optional build macro STROBED_READER_UNDERRUN_HOLD_EN: underrun slots repeat
// the previously emitted sample instead of emitting zero.
module axis_strobed_reader #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 start,
  input  logic [LEN_W-1:0]     pkt_len,
  input  logic [LEN_W-1:0]     prefill,
  input  logic [LEN_W-1:0]     occupied,
  axis_strobed_reader_if.slave s_axis,
  input  logic                 sample_strobe,
  output logic [WIDTH-1:0]     o_sample,
  output logic                 o_sample_valid,
  output logic                 o_last,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_FILL = 2'd1,
    S_STREAM    = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_thr;
  logic             w_slot;
  logic             w_pop;
  logic             w_starve;
  logic             w_accept;

  // Next-state decode and per-cycle slot classification.
  always_comb begin
    w_state_nxt = r_state;
    w_slot      = 1'b0;
    w_pop       = 1'b0;
    w_starve    = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (pkt_len == '0) ? S_DONE : S_WAIT_FILL;
        end
      end
      S_WAIT_FILL: begin
        if (occupied >= r_thr) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_slot   = sample_strobe;
        w_pop    = sample_strobe & s_axis.s_tvalid;
        w_starve = sample_strobe & ~s_axis.s_tvalid;
        if (w_pop && (r_remaining == LEN_W'(1))) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign s_axis.s_tready = w_slot;
  assign busy            = (r_state != S_IDLE);

  // State register; reset and clear both abort to IDLE.
  always_ff @(posedge clk) begin
    if (reset || clear) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Packet bookkeeping and the registered, strobe-aligned sample outputs.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_remaining    <= '0;
      r_thr          <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_last         <= 1'b0;
      done           <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      o_last         <= 1'b0;
      done           <= (r_state == S_DONE);
      if (w_accept) begin
        r_remaining <= pkt_len;
        r_thr       <= (prefill < pkt_len) ? prefill : pkt_len;
        underrun    <= 1'b0;
      end
      if (w_pop) begin
        o_sample       <= s_axis.s_tdata;
        o_sample_valid <= 1'b1;
        o_last         <= (r_remaining == LEN_W'(1));
        r_remaining    <= r_remaining - LEN_W'(1);
      end else if (w_starve) begin
`ifdef STROBED_READER_UNDERRUN_HOLD_EN
        o_sample       <= o_sample;
`else
        o_sample       <= '0;
`endif
        o_sample_valid <= 1'b1;
        underrun       <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_strobed_reader.md
Name: axis_strobed_reader

Overview:
- Consumer-side drain engine for the TX sample block-RAM FIFO.
- Waits until the FIFO holds a prefill threshold, then pops one sample per sample_strobe and presents it to the DAC/IQ path as a registered, strobe-aligned sample.
- Frames each packet with a last flag, flags underruns and reports completion.

Parameters:
WIDTH, 32, sample/data width (matches the FIFO data width)
LEN_W, 16, width of packet-length, prefill and occupancy fields

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous abort to IDLE; same register effect as reset
start  in  1  one-cycle request to send one packet; accepted only in IDLE
pkt_len  in  LEN_W  samples in packet; sampled on accepted start
prefill  in  LEN_W  FIFO occupancy required before streaming; sampled on accepted start
occupied  in  LEN_W  FIFO occupancy count
s_tdata  in  WIDTH  FIFO output data
s_tvalid  in  1  FIFO output valid
s_tready  out  1  pop FIFO; combinational = (state==STREAM) & sample_strobe
sample_strobe  in  1  one-cycle sample-rate tick
o_sample  out  WIDTH  registered sample to DAC path
o_sample_valid  out  1  one-cycle pulse per emitted sample slot
o_last  out  1  coincides with o_sample_valid of final packet sample
busy  out  1  high when state != IDLE
done  out  1  one-cycle pulse at packet completion
underrun  out  1  sticky; set when a strobe finds FIFO empty during STREAM

Behaviour:
- Reset/clear values:
  - state=IDLE; o_sample=0; o_sample_valid=0; o_last=0; done=0; underrun=0; remaining=0; thr=0.
  - clear has priority over start.
  - Reset or clear mid-packet aborts without asserting done; FIFO contents are not touched.
- States: IDLE, WAIT_FILL, STREAM, DONE (2-bit encoding).
- IDLE: start=1 latches remaining=pkt_len, thr=min(prefill,pkt_len), clears underrun.
  - pkt_len=0 -> DONE.
  - Otherwise -> WAIT_FILL.
  - start in any other state is ignored.
- WAIT_FILL:
  - occupied >= thr (unsigned compare) -> STREAM next cycle.
  - thr=0 passes immediately.
  - Strobes in WAIT_FILL are ignored: no pop, no output.
- STREAM, on sample_strobe:
  - s_tvalid=1 (pop):
    - o_sample <= s_tdata; o_sample_valid <= 1; remaining <= remaining-1.
    - If remaining==1: o_last <= 1 and -> DONE.
  - s_tvalid=0 (underrun):
    - o_sample <= 0 (see optional feature); o_sample_valid <= 1 (DAC slot still filled); o_last <= 0; underrun <= 1.
    - remaining is NOT decremented; the packet payload is preserved and resumes when data arrives.
- No strobe: o_sample_valid and o_last return to 0; o_sample holds its last value.
- Latency: o_sample/o_sample_valid/o_last are registered one cycle after the strobe cycle.
- DONE: done=1 for exactly one cycle -> IDLE. A start arriving in the DONE cycle is ignored.
- Strobes closer than 1 cycle apart (back-to-back) are legal; each pops one word. The FIFO registered output supports this.
- remaining is LEN_W bits; pkt_len max = 2^LEN_W-1. No wrap is possible since decrement stops at DONE.
- Extra FIFO words beyond pkt_len are never popped.

Optional Feature:
- Macro STROBED_READER_UNDERRUN_HOLD_EN.
- Defined: on an underrun slot, o_sample repeats the previously emitted sample (reset value 0) instead of 0.
- Undefined: on an underrun slot, o_sample = 0.
- Underrun flag, o_sample_valid and remaining behaviour are identical in both builds.

Test Plan:
- Basic packet:
  - Stimulus: pkt_len=4, prefill=2, FIFO preloaded 0xA1..0xA4, strobe every 4 cycles.
  - Response: four o_sample_valid pulses with 0xA1..0xA4, o_last on 0xA4, done 1 cycle later, underrun=0, busy low after done.
- Prefill gating:
  - Stimulus: pkt_len=8, prefill=6, occupied ramps 0..8 with strobes running.
  - Response: no s_tready/o_sample_valid until the cycle after occupied reaches 6.
- Underrun:
  - Stimulus: pkt_len=3, prefill=1, FIFO gets 0x11, then empty for 2 strobes, then 0x22, 0x33.
  - Response: samples 0x11,0,0,0x22,0x33 (hold build: 0x11,0x11,0x11,0x22,0x33), underrun=1, o_last on 0x33, exactly 3 pops.
- Zero length and overfill:
  - Stimulus: pkt_len=0.
  - Response: done pulses 2 cycles after start, no pops.
  - Stimulus: pkt_len=2 with 5 words in the FIFO.
  - Response: exactly 2 pops, 3 words remain.
- Abort:
  - Stimulus: clear asserted after 2 of 6 samples.
  - Response: state IDLE next cycle, no done, o_sample_valid=0, o_sample=0, underrun=0.
  - Stimulus: new start afterwards.
  - Response: sends a full new packet.
- Back-to-back:
  - Stimulus: sample_strobe held high for 5 cycles, pkt_len=5, FIFO full.
  - Response: 5 consecutive o_sample_valid cycles, o_last on the 5th.
